// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if -- operation/result handshake bundle for pipelined_alu.
// The master drives operations and accepts results; the slave is the ALU.
interface pipelined_alu_if #(
   parameter int WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_carry;
   logic             flag_zero;
   logic             flag_neg;
   logic             flag_ovf;

   modport master (
      output in_valid, op, operand_a, operand_b, out_ready,
      input  in_ready, out_valid, result, flag_carry, flag_zero, flag_neg, flag_ovf
   );

   modport slave (
      input  in_valid, op, operand_a, operand_b, out_ready,
      output in_ready, out_valid, result, flag_carry, flag_zero, flag_neg, flag_ovf
   );
endinterface

// File: rtl/pipelined_alu.sv
// pipelined_alu -- two-stage pipelined ALU with valid/ready on both sides.
// Stage 1 registers the incoming operation; stage 2 evaluates it against the
// accumulator / previous-operand state and registers result plus flags.
// Optional build macro PIPELINED_ALU_SATURATE_EN: arithmetic results clamp
// (all-ones on carry, zero on borrow) instead of wrapping, ovf reads 0.
module pipelined_alu #(
   parameter int WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 resetn,
   pipelined_alu_if.slave       bus
);

   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_ACC   = 3'b101;
   localparam logic [2:0] OP_DELTA = 3'b110;
   localparam logic [2:0] OP_CLR   = 3'b111;

   // stage-1 registers
   logic             s1_valid;
   logic [2:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   // stage-2 / output registers and architectural state
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             flag_carry, flag_zero, flag_neg, flag_ovf;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] prev;

   // pipeline enables: a stage advances when its downstream slot frees up
   logic en1, en2, fire2;

   assign en2   = !out_valid || bus.out_ready;
   assign en1   = !s1_valid || en2;
   assign fire2 = s1_valid && en2;

   // operand selection and arithmetic mode for the stage-2 adder
   logic [WIDTH-1:0] x, y, logic_res;
   logic             is_sub, is_arith;

   // Pick adder operands and mode from the stage-1 opcode.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      x         = s1_a;
      y         = s1_b;
      is_sub    = 1'b0;
      is_arith  = 1'b0;
      logic_res = '0;
      case (s1_op)
         OP_ADD:   is_arith = 1'b1;
         OP_SUB:   begin is_arith = 1'b1; is_sub = 1'b1; end
         OP_AND:   logic_res = s1_a & s1_b;
         OP_OR:    logic_res = s1_a | s1_b;
         OP_XOR:   logic_res = s1_a ^ s1_b;
         OP_ACC:   begin x = acc;  y = s1_a; is_arith = 1'b1; end
         // legacy compare-select: add when prev is strictly below a, else subtract
         OP_DELTA: begin x = prev; y = s1_a; is_arith = 1'b1; is_sub = !(prev < s1_a); end
         default:  logic_res = '0;
      endcase
   end

   // WIDTH+1-bit adder; the top bit is carry on add and borrow on subtract
   logic [WIDTH:0]   ext;
   logic [WIDTH-1:0] raw;
   logic             carry_raw, ovf_raw;

   assign ext       = is_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
   assign raw       = ext[MSB:0];
   assign carry_raw = ext[WIDTH];
   assign ovf_raw   = is_sub ? ((x[MSB] != y[MSB]) && (raw[MSB] != x[MSB]))
                             : ((x[MSB] == y[MSB]) && (raw[MSB] != x[MSB]));

   logic [WIDTH-1:0] nxt_result, nxt_acc, nxt_prev;
   logic             nxt_carry, nxt_ovf;

   // Final result/flags (with optional clamping) and next state values.
   always_comb begin
      nxt_carry = is_arith && carry_raw;
`ifdef PIPELINED_ALU_SATURATE_EN
      nxt_ovf = 1'b0;
      if (!is_arith)
         nxt_result = logic_res;
      else if (carry_raw)
         nxt_result = is_sub ? '0 : '1;
      else
         nxt_result = raw;
`else
      nxt_ovf    = is_arith && ovf_raw;
      nxt_result = is_arith ? raw : logic_res;
`endif
      nxt_acc  = acc;
      nxt_prev = prev;
      if (s1_op == OP_ACC)   nxt_acc  = nxt_result;
      if (s1_op == OP_DELTA) nxt_prev = s1_a;
      if (s1_op == OP_CLR) begin
         nxt_acc  = '0;
         nxt_prev = '0;
      end
   end

   // Stage 1: capture the offered operation whenever the slot can advance.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (en1) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         s1_valid <= bus.in_valid;
         s1_op    <= bus.op;
         s1_a     <= bus.operand_a;
         s1_b     <= bus.operand_b;
      end
   end

   // Stage 2: register result/flags and commit acc/prev for a valid operation.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         // NOTE: datapath registers are reset too, since result and flags must read zero during reset.
         out_valid  <= 1'b0;
         result     <= '0;
         flag_carry <= 1'b0;
         flag_zero  <= 1'b0;
         flag_neg   <= 1'b0;
         flag_ovf   <= 1'b0;
         acc        <= '0;
         prev       <= '0;
      end else begin
         if (en2) out_valid <= s1_valid;
         if (fire2) begin
            result     <= nxt_result;
            flag_carry <= nxt_carry;
            flag_zero  <= (nxt_result == '0);
            flag_neg   <= nxt_result[MSB];
            flag_ovf   <= nxt_ovf;
            acc        <= nxt_acc;
            prev       <= nxt_prev;
         end
      end
   end

   assign bus.in_ready   = en1;
   assign bus.out_valid  = out_valid;
   assign bus.result     = result;
   assign bus.flag_carry = flag_carry;
   assign bus.flag_zero  = flag_zero;
   assign bus.flag_neg   = flag_neg;
   assign bus.flag_ovf   = flag_ovf;

endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu -- directed plus randomized bench for pipelined_alu.
// A behavioural model (integer arithmetic on accepted operations) predicts
// every emitted result; directed sequences pin the model with literals.
module tb_pipelined_alu;

   localparam int WIDTH = 8;
   localparam int MOD   = 1 << WIDTH;
   localparam int HALF  = MOD / 2;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                          XOR_ = 3'd4, ACC = 3'd5, DELTA = 3'd6, CLR = 3'd7;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   always #5 clock = ~clock;

   pipelined_alu_if #(.WIDTH(WIDTH)) bus ();

   pipelined_alu #(.WIDTH(WIDTH)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } obs_t;

   int          n_compared   = 0;
   int          n_mismatched = 0;
   int          cyc          = 0;
   int          m_acc        = 0;
   int          m_prev       = 0;
   logic [31:0] exp_q[$];
   obs_t        out_log[$];
   int          acc_log[$];
   bit          stall_prev   = 1'b0;
   logic [31:0] stall_snap   = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {result, carry, zero, neg, ovf} packed into one word
   function automatic logic [31:0] lit(input int res, input bit c, input bit z, input bit n, input bit v);
      logic [31:0] r;
      r = 32'(res);
      return (r << 4) | {28'b0, c, z, n, v};
   endfunction

   function automatic logic [31:0] outs();
      logic [31:0] r;
      r = '0;
      r[WIDTH+3:0] = {bus.result, bus.flag_carry, bus.flag_zero, bus.flag_neg, bus.flag_ovf};
      return r;
   endfunction

   // signed-range based add/subtract model
   function automatic logic [31:0] arith(input bit is_sub, input int x, input int y, output int val);
      int r, sx, sy, sr;
      bit c, v;
      r  = is_sub ? x - y : x + y;
      c  = is_sub ? (r < 0) : (r >= MOD);
      sx = (x >= HALF) ? x - MOD : x;
      sy = (y >= HALF) ? y - MOD : y;
      sr = is_sub ? sx - sy : sx + sy;
      v  = (sr < -HALF) || (sr >= HALF);
      val = ((r % MOD) + MOD) % MOD;
`ifdef PIPELINED_ALU_SATURATE_EN
      if (c) val = is_sub ? 0 : MOD - 1;
      v = 1'b0;
`endif
      return lit(val, c, val == 0, val >= HALF, v);
   endfunction

   function automatic logic [31:0] bitwise(input int val);
      return lit(val, 1'b0, val == 0, val >= HALF, 1'b0);
   endfunction

   // Behavioural model: applied once per accepted operation, in order.
   function automatic logic [31:0] model(input int op, input int a, input int b);
      int val;
      logic [31:0] e;
      e = '0;
      case (op)
         0: e = arith(1'b0, a, b, val);
         1: e = arith(1'b1, a, b, val);
         2: e = bitwise(a & b);
         3: e = bitwise(a | b);
         4: e = bitwise(a ^ b);
         5: begin e = arith(1'b0, m_acc, a, val); m_acc = val; end
         6: begin
            if (m_prev < a) e = arith(1'b0, m_prev, a, val);
            else            e = arith(1'b1, m_prev, a, val);
            m_prev = a;
         end
         default: begin m_acc = 0; m_prev = 0; e = lit(0, 1'b0, 1'b1, 1'b0, 1'b0); end
      endcase
      return e;
   endfunction

   // Monitor: sample mid-cycle, predict on accept, compare on emit, check holds.
   always @(negedge clock) begin
      cyc++;
      if (resetn) begin
         if (stall_prev) check("hold_stable", outs(), stall_snap);
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(int'(bus.op), int'(bus.operand_a), int'(bus.operand_b)));
            acc_log.push_back(cyc);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", outs(), 32'hFFFF_FFFF);
            else                   check("scoreboard", outs(), exp_q.pop_front());
            out_log.push_back('{cyc: cyc, val: outs()});
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         stall_snap = outs();
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic send(input logic [2:0] op, input int a, input int b);
      @(posedge clock); #1;
      bus.in_valid  = 1'b1;
      bus.op        = op;
      bus.operand_a = a[WIDTH-1:0];
      bus.operand_b = b[WIDTH-1:0];
      for (int i = 0; ; i++) begin
         @(negedge clock);
         if (bus.in_ready) break;
         if (i >= 200) begin
            check("accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clock);
   endtask

   task automatic clear_logs();
      out_log.delete();
      acc_log.delete();
   endtask

   function automatic int rand_operand();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return MOD - 1;
         2: return HALF - 1;
         3: return HALF;
         default: return int'($urandom_range(0, MOD - 1));
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit done;
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.out_ready = 1'b1;

      // ---- reset state ----
      #1;
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_outs", outs(), lit(0, 1'b0, 1'b0, 1'b0, 1'b0));
      #21 resetn = 1'b1;
      #1 check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

      // ---- flush: add / sub / overflow ----
      clear_logs();
      send(ADD, 'hF0, 'h20);
      send(SUB, 'h05, 'h05);
      send(SUB, 'h03, 'h05);
      send(ADD, 'h7F, 'h01);
      idle(5);
      check("flush_count", 32'(out_log.size()), 32'd4);
      if (out_log.size() >= 4 && acc_log.size() >= 1) begin
         check("flush_latency", 32'(out_log[0].cyc - acc_log[0]), 32'd2);
         check("add_f0_20", out_log[0].val, lit('h10, 1'b1, 1'b0, 1'b0, 1'b0));
         check("sub_5_5",   out_log[1].val, lit('h00, 1'b0, 1'b1, 1'b0, 1'b0));
         check("sub_3_5",   out_log[2].val, lit('hFE, 1'b1, 1'b0, 1'b1, 1'b0));
`ifdef PIPELINED_ALU_SATURATE_EN
         check("add_7f_1",  out_log[3].val, lit('h80, 1'b0, 1'b0, 1'b1, 1'b0));
`else
         check("add_7f_1",  out_log[3].val, lit('h80, 1'b0, 1'b0, 1'b1, 1'b1));
`endif
      end

      // ---- DELTA legacy mode, back-to-back ----
      clear_logs();
      send(CLR, 0, 0);
      send(DELTA, 10, 0);
      send(DELTA, 20, 0);
      send(DELTA, 5, 0);
      idle(5);
      check("delta_count", 32'(out_log.size()), 32'd4);
      if (out_log.size() >= 4) begin
         check("clr_result", out_log[0].val, lit(0, 1'b0, 1'b1, 1'b0, 1'b0));
         check("delta_10",   out_log[1].val, lit(10, 1'b0, 1'b0, 1'b0, 1'b0));
         check("delta_20",   out_log[2].val, lit(30, 1'b0, 1'b0, 1'b0, 1'b0));
         check("delta_5",    out_log[3].val, lit(15, 1'b0, 1'b0, 1'b0, 1'b0));
         check("delta_contig", 32'(out_log[3].cyc - out_log[0].cyc), 32'd3);
      end

      // ---- backpressure ----
      clear_logs();
      bus.out_ready = 1'b0;
      send(ADD, 1, 1);
      send(ADD, 2, 2);
      @(posedge clock); #1;
      bus.op        = ADD;
      bus.operand_a = 8'd3;
      bus.operand_b = 8'd3;
      repeat (3) begin
         @(negedge clock);
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         check("stall_out_valid", 32'(bus.out_valid), 32'd1);
         check("stall_result", 32'(bus.result), 32'h02);
      end
      @(posedge clock); #1;
      bus.out_ready = 1'b1;
      for (int i = 0; ; i++) begin
         @(negedge clock);
         if (bus.in_ready) break;
         if (i >= 50) begin
            check("drain_accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      idle(6);
      check("stall_count", 32'(out_log.size()), 32'd3);
      if (out_log.size() >= 3) begin
         check("stall_r0", 32'(out_log[0].val >> 4), 32'h02);
         check("stall_r1", 32'(out_log[1].val >> 4), 32'h04);
         check("stall_r2", 32'(out_log[2].val >> 4), 32'h06);
      end

      // ---- accumulator ----
      clear_logs();
      send(CLR, 0, 0);
      send(ACC, 'h80, 0);
      send(ACC, 'h90, 0);
      send(ACC, 'h01, 0);
      idle(5);
      check("acc_count", 32'(out_log.size()), 32'd4);
      if (out_log.size() >= 4) begin
         check("acc_80", out_log[1].val, lit('h80, 1'b0, 1'b0, 1'b1, 1'b0));
`ifdef PIPELINED_ALU_SATURATE_EN
         check("acc_90", out_log[2].val, lit('hFF, 1'b1, 1'b0, 1'b1, 1'b0));
         check("acc_01", out_log[3].val, lit('hFF, 1'b1, 1'b0, 1'b1, 1'b0));
`else
         check("acc_90", out_log[2].val, lit('h10, 1'b1, 1'b0, 1'b0, 1'b1));
         check("acc_01", out_log[3].val, lit('h11, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
      end

      // ---- reset mid-stream ----
      send(DELTA, 50, 0);
      send(ADD, 1, 2);
      send(ADD, 3, 4);
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      resetn = 1'b0;
      #1;
      check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
      check("midreset_outs", outs(), lit(0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.delete();
      m_acc  = 0;
      m_prev = 0;
      repeat (2) @(posedge clock);
      #2 resetn = 1'b1;
      clear_logs();
      send(DELTA, 7, 0);
      idle(5);
      check("post_reset_count", 32'(out_log.size()), 32'd1);
      if (out_log.size() >= 1)
         check("post_reset_delta7", out_log[0].val, lit(7, 1'b0, 1'b0, 1'b0, 1'b0));

      // ---- randomized traffic with random backpressure ----
      done = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clock); #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (done) begin
            bus.in_valid  = ($urandom_range(0, 4) != 0);
            bus.op        = 3'($urandom_range(0, 7));
            bus.operand_a = WIDTH'(rand_operand());
            bus.operand_b = WIDTH'(rand_operand());
         end
         @(negedge clock);
         done = !bus.in_valid || bus.in_ready;
      end
      @(posedge clock); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clock);
      repeat (3) @(posedge clock);
      check("final_outstanding", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Parametrised, two-stage pipelined successor to the team's 8-bit registered add/subtract ALU.
- Accepts one operation per cycle over a valid/ready handshake and returns a result plus flags two cycles later.
- Carries two pieces of state:
  - a "previous operand" register for the legacy compare-select (DELTA) mode;
  - an accumulator for running sums.
- Sits between the operand register file and the memory-transfer datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous, active-low reset
in_valid  input  1  operation presented
in_ready  output  1  operation accepted when in_valid && in_ready
op  input  3  operation code (see Behaviour)
operand_a  input  WIDTH  first operand
operand_b  input  WIDTH  second operand
out_valid  output  1  result/flags valid
out_ready  input  1  downstream accepts when out_valid && out_ready
result  output  WIDTH  operation result
flag_carry  output  1  carry-out (ADD/ACC) or borrow (SUB/DELTA-sub)
flag_zero  output  1  result == 0
flag_neg  output  1  result MSB
flag_ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: while resetn is low, all registers clear asynchronously.
  - out_valid=0, result=0, all flags=0.
  - Stage-1 valid, accumulator and prev register = 0.
  - in_ready=1 once resetn is high.
  - Any in-flight operation is discarded, never emitted.
- Pipeline:
  - en2 = !out_valid || out_ready.
  - en1 = !s1_valid || en2.
  - in_ready = en1. This is a combinational path from out_ready; it is permitted.
- Stage 1: on en1, capture op/operand_a/operand_b and s1_valid <= in_valid.
- Stage 2: on en2, compute from the stage-1 registers and the state registers, then register result, flags and out_valid <= s1_valid.
- Latency: 2 cycles from accept to out_valid when unstalled. Throughput is 1 op/cycle.
- Ordering: results appear in acceptance order, with no drop or duplication under any out_ready pattern.
- State registers are read and written only in stage 2, when s1_valid && en2. Back-to-back dependent operations therefore need no forwarding.
- Arithmetic is computed at WIDTH+1 bits. result = low WIDTH bits.
- op codes:
  - 000 ADD: a+b. carry = bit WIDTH.
  - 001 SUB: a-b. carry = borrow (a<b, unsigned).
  - 010 AND, 011 OR, 100 XOR: bitwise. carry=0, ovf=0.
  - 101 ACC: acc <= acc+a. result = new acc. carry/ovf as for ADD.
  - 110 DELTA (legacy mode):
    - if prev < a (unsigned): result = prev+a, with ADD flags;
    - else: result = prev-a, with SUB flags;
    - in both cases prev <= a.
  - 111 CLR: acc <= 0, prev <= 0. result=0, zero=1, other flags 0.
- prev is updated only by DELTA and CLR. acc is updated only by ACC and CLR.
- flag_zero and flag_neg always reflect the final result.
- ovf: set when ADD-type operands have equal sign and the result sign differs, or when SUB-type operands have differing sign and the result sign differs from a (from prev in DELTA).
- Outputs hold stable while out_valid && !out_ready.

Optional Feature:
- Macro: PIPELINED_ALU_SATURATE_EN.
- Defined: ADD, ACC and DELTA-add clamp result to all-ones on carry; SUB and DELTA-sub clamp to 0 on borrow.
  - The accumulator stores the clamped value.
  - flag_carry still reports the unclamped carry/borrow.
  - flag_zero and flag_neg follow the clamped result.
  - flag_ovf is forced to 0.
- Undefined: modulo-2^WIDTH wrap-around as above.

Test Plan:
- Flush (all benches use WIDTH=8, out_ready=1): ADD a=0xF0 b=0x20, accepted at cycle N -> out_valid at N+2, result=0x10, carry=1, zero=0, neg=0, ovf=0.
- SUB 0x05-0x05 -> result 0x00, zero=1, carry=0. Then SUB 0x03-0x05 -> 0xFE, carry=1, neg=1. Then ADD 0x7F+0x01 -> 0x80, ovf=1, neg=1.
- CLR, then DELTA a=10, a=20, a=5 back-to-back -> results 10 (0+10), 30 (10<20, add), 15 (20>=5, sub). Result stream is contiguous, one per cycle.
- Hold out_ready=0 and offer 3 ops (ADD 1+1, ADD 2+2, ADD 3+3):
  - first two are accepted, then in_ready=0;
  - result stays 0x02 and stable;
  - release out_ready -> 0x02, 0x04, 0x06 in order, third op accepted when the pipeline drains.
- CLR, ACC 0x80, ACC 0x90 -> results 0x80 then 0x10 with carry=1. With PIPELINED_ALU_SATURATE_EN defined, the second result is 0xFF with carry=1, and a subsequent ACC 0x01 returns 0xFF.
- Pulse resetn low mid-stream with out_valid=1 and s1 occupied -> out_valid=0 and result=0 immediately. After release, the first DELTA a=7 returns 7 (prev cleared) and no stale result appears.
